// File: rtl/v60_prefetch_queue.sv
// v60_prefetch_queue: instruction prefetch byte queue and fetch sequencer
// presenting the oldest six bytes as a decode window. Rev 1.0
`default_nettype none

module v60_prefetch_queue #(
   parameter int          QUEUE_BYTES = 16,
   parameter logic [31:0] RESET_PC    = 32'hFFFF_FFF0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [47:0] inst,
   output logic        inst_valid,
   output logic [31:0] inst_pc,
   input  logic        consume,
   input  logic [2:0]  consume_len,
   output logic        len_err,
   output logic [4:0]  q_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  queue_q [QUEUE_BYTES];
   logic [7:0]  queue_d [QUEUE_BYTES];
   logic [4:0]  count_q, count_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] fptr_q, fptr_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  skip_q, skip_d;
   logic        len_err_q, len_err_d;

   logic        consume_ok;
   logic        take;
   logic [2:0]  shift;
   logic [2:0]  fill;
   logic [5:0]  base;

   always_comb begin
      consume_ok = consume && (consume_len != 3'd0) && (consume_len != 3'd7)
                   && ({2'b00, consume_len} <= count_q);
      take  = (state_q == S_REQ) && mem_ack;
      shift = consume_ok ? consume_len : 3'd0;
      fill  = take ? (3'd4 - {1'b0, skip_q}) : 3'd0;
      base  = {1'b0, count_q} - {3'b000, shift};

      // Shift out retired bytes, then append the fetched bytes behind the survivors.
      for (int i = 0; i < QUEUE_BYTES; i++) begin
         queue_d[i] = 8'h00;
         if (i < int'(base)) begin
            queue_d[i] = queue_q[i + int'(shift)];
         end else if ((i - int'(base)) < int'(fill)) begin
            queue_d[i] = mem_rdata[8*(int'(skip_q) + i - int'(base)) +: 8];
         end
      end
      count_d   = base[4:0] + {2'b00, fill};
      pc_d      = pc_q + {29'd0, shift};
      fptr_d    = take ? (fptr_q + 32'd4) : fptr_q;
      skip_d    = take ? 2'd0 : skip_q;
      len_err_d = consume && !consume_ok && !flush;

      if (flush) begin
         for (int i = 0; i < QUEUE_BYTES; i++) begin
            queue_d[i] = 8'h00;
         end
         count_d = 5'd0;
         pc_d    = flush_pc;
         fptr_d  = {flush_pc[31:2], 2'b00};
         skip_d  = flush_pc[1:0];
      end
   end

   // The request address is latched at issue so a flush during DROP cannot disturb it.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      case (state_q)
         S_IDLE: begin
            if (!flush && (count_q <= 5'(QUEUE_BYTES - 4))) begin
               state_d = S_REQ;
               addr_d  = fptr_q;
            end
         end
         S_REQ: begin
            if (flush && !mem_ack) state_d = S_DROP;
            else if (mem_ack)      state_d = S_IDLE;
         end
         S_DROP: begin
            if (mem_ack) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         count_q   <= 5'd0;
         pc_q      <= RESET_PC;
         fptr_q    <= {RESET_PC[31:2], 2'b00};
         addr_q    <= {RESET_PC[31:2], 2'b00};
         skip_q    <= RESET_PC[1:0];
         len_err_q <= 1'b0;
         for (int i = 0; i < QUEUE_BYTES; i++) begin
            queue_q[i] <= 8'h00;
         end
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         pc_q      <= pc_d;
         fptr_q    <= fptr_d;
         addr_q    <= addr_d;
         skip_q    <= skip_d;
         len_err_q <= len_err_d;
         for (int i = 0; i < QUEUE_BYTES; i++) begin
            queue_q[i] <= queue_d[i];
         end
      end
   end

   assign mem_req    = (state_q != S_IDLE);
   assign mem_addr   = addr_q;
   assign inst       = {queue_q[0], queue_q[1], queue_q[2], queue_q[3], queue_q[4], queue_q[5]};
   assign inst_valid = (count_q >= 5'd6);
   assign inst_pc    = pc_q;
   assign len_err    = len_err_q;
   assign q_count    = count_q;

endmodule

`default_nettype wire

// File: tb/tb_v60_prefetch_queue.sv
// tb_v60_prefetch_queue: directed self-checking bench for v60_prefetch_queue. Rev 1.0
`default_nettype none

module tb_v60_prefetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [31:0] flush_pc;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [47:0] inst;
   logic        inst_valid;
   logic [31:0] inst_pc;
   logic        consume;
   logic [2:0]  consume_len;
   logic        len_err;
   logic [4:0]  q_count;

   int tests = 0;
   int fails = 0;

   v60_prefetch_queue #(.QUEUE_BYTES(16), .RESET_PC(32'hFFFF_FFF0)) dut (
      .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .inst(inst), .inst_valid(inst_valid), .inst_pc(inst_pc),
      .consume(consume), .consume_len(consume_len), .len_err(len_err), .q_count(q_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input string nm);
      int n = 0;
      while (!mem_req && n < 20) begin
         step();
         n++;
      end
      tests++;
      if (!mem_req) begin
         fails++;
         $display("FAIL %s: mem_req timeout, got %0b expected 1", nm, mem_req);
      end
   endtask

   task automatic ack_word(input logic [31:0] data);
      mem_ack   = 1'b1;
      mem_rdata = data;
      step();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
   endtask

   task automatic do_consume(input logic [2:0] len);
      consume     = 1'b1;
      consume_len = len;
      step();
      consume     = 1'b0;
      consume_len = 3'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      tests++;
      if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %0b expected 0", mem_req); end
      tests++;
      if (q_count !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", q_count); end
      tests++;
      if (inst !== 48'h0 || inst_valid !== 1'b0) begin
         fails++; $display("FAIL reset_inst: got %h/%0b expected 0/0", inst, inst_valid);
      end
      tests++;
      if (inst_pc !== 32'hFFFF_FFF0) begin fails++; $display("FAIL reset_pc: got %h expected fffffff0", inst_pc); end
      tests++;
      if (len_err !== 1'b0) begin fails++; $display("FAIL reset_len_err: got %0b expected 0", len_err); end
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_fill();
      wait_req("fill_req0");
      tests++;
      if (mem_addr !== 32'hFFFF_FFF0) begin fails++; $display("FAIL fill_addr0: got %h expected fffffff0", mem_addr); end
      ack_word(32'h0302_0100);
      tests++;
      if (q_count !== 5'd4) begin fails++; $display("FAIL fill_count4: got %0d expected 4", q_count); end
      wait_req("fill_req1");
      tests++;
      if (mem_addr !== 32'hFFFF_FFF4) begin fails++; $display("FAIL fill_addr1: got %h expected fffffff4", mem_addr); end
      ack_word(32'h0706_0504);
      tests++;
      if (inst !== 48'h0001_0203_0405) begin fails++; $display("FAIL fill_inst: got %h expected 000102030405", inst); end
      tests++;
      if (inst_valid !== 1'b1) begin fails++; $display("FAIL fill_valid: got %0b expected 1", inst_valid); end
      tests++;
      if (inst_pc !== 32'hFFFF_FFF0) begin fails++; $display("FAIL fill_pc: got %h expected fffffff0", inst_pc); end
      tests++;
      if (q_count !== 5'd8) begin fails++; $display("FAIL fill_count8: got %0d expected 8", q_count); end
   endtask

   task automatic test_consume();
      do_consume(3'd2);
      tests++;
      if (q_count !== 5'd6) begin fails++; $display("FAIL cons2_count: got %0d expected 6", q_count); end
      tests++;
      if (inst_pc !== 32'hFFFF_FFF2) begin fails++; $display("FAIL cons2_pc: got %h expected fffffff2", inst_pc); end
      tests++;
      if (inst !== 48'h0203_0405_0607) begin fails++; $display("FAIL cons2_inst: got %h expected 020304050607", inst); end
      wait_req("cons_req");
      tests++;
      if (mem_addr !== 32'hFFFF_FFF8) begin fails++; $display("FAIL cons_addr: got %h expected fffffff8", mem_addr); end
      consume     = 1'b1;
      consume_len = 3'd5;
      ack_word(32'h0B0A_0908);
      consume     = 1'b0;
      consume_len = 3'd0;
      tests++;
      if (q_count !== 5'd5) begin fails++; $display("FAIL cons5_ack_count: got %0d expected 5", q_count); end
      tests++;
      if (inst_pc !== 32'hFFFF_FFF7) begin fails++; $display("FAIL cons5_pc: got %h expected fffffff7", inst_pc); end
      tests++;
      if (inst !== 48'h0708_090A_0B00 || inst_valid !== 1'b0) begin
         fails++; $display("FAIL cons5_inst: got %h/%0b expected 0708090a0b00/0", inst, inst_valid);
      end
   endtask

   task automatic test_wrap();
      wait_req("wrap_req0");
      tests++;
      if (mem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_addr0: got %h expected fffffffc", mem_addr); end
      ack_word(32'h0F0E_0D0C);
      wait_req("wrap_req1");
      tests++;
      if (mem_addr !== 32'h0000_0000) begin fails++; $display("FAIL wrap_addr1: got %h expected 00000000", mem_addr); end
      ack_word(32'h1312_1110);
      tests++;
      if (q_count !== 5'd13) begin fails++; $display("FAIL wrap_count: got %0d expected 13", q_count); end
   endtask

   task automatic test_flush_align();
      flush    = 1'b1;
      flush_pc = 32'h0000_1003;
      step();
      flush    = 1'b0;
      tests++;
      if (q_count !== 5'd0 || inst_pc !== 32'h0000_1003) begin
         fails++; $display("FAIL flush_state: got %0d/%h expected 0/00001003", q_count, inst_pc);
      end
      wait_req("flush_req0");
      tests++;
      if (mem_addr !== 32'h0000_1000) begin fails++; $display("FAIL flush_addr0: got %h expected 00001000", mem_addr); end
      ack_word(32'hAABB_CCDD);
      tests++;
      if (q_count !== 5'd1) begin fails++; $display("FAIL flush_skip_count: got %0d expected 1", q_count); end
      tests++;
      if (inst !== 48'hAA00_0000_0000 || inst_pc !== 32'h0000_1003) begin
         fails++; $display("FAIL flush_skip_inst: got %h/%h expected aa0000000000/00001003", inst, inst_pc);
      end
      wait_req("flush_req1");
      tests++;
      if (mem_addr !== 32'h0000_1004) begin fails++; $display("FAIL flush_addr1: got %h expected 00001004", mem_addr); end
   endtask

   task automatic test_flush_pending();
      flush    = 1'b1;
      flush_pc = 32'h0000_2000;
      step();
      flush    = 1'b0;
      step();
      step();
      tests++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0000_1004) begin
         fails++; $display("FAIL drop_hold: got %0b/%h expected 1/00001004", mem_req, mem_addr);
      end
      tests++;
      if (q_count !== 5'd0 || inst_pc !== 32'h0000_2000) begin
         fails++; $display("FAIL drop_state: got %0d/%h expected 0/00002000", q_count, inst_pc);
      end
      ack_word(32'h5555_5555);
      tests++;
      if (q_count !== 5'd0) begin fails++; $display("FAIL drop_discard: got %0d expected 0", q_count); end
      wait_req("drop_req");
      tests++;
      if (mem_addr !== 32'h0000_2000 || q_count !== 5'd0) begin
         fails++; $display("FAIL drop_next: got %h/%0d expected 00002000/0", mem_addr, q_count);
      end
   endtask

   task automatic test_full();
      int seen = 0;
      test_reset();
      for (int w = 0; w < 4; w++) begin
         wait_req("full_req");
         ack_word(32'h1000_0000 + 32'(w));
      end
      tests++;
      if (q_count !== 5'd16) begin fails++; $display("FAIL full_count: got %0d expected 16", q_count); end
      for (int c = 0; c < 8; c++) begin
         if (mem_req) seen++;
         step();
      end
      tests++;
      if (seen != 0) begin fails++; $display("FAIL full_no_req: got %0d request cycles expected 0", seen); end
      do_consume(3'd4);
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         if (mem_req) begin
            seen++;
            ack_word(32'hCAFE_F00D);
         end else begin
            step();
         end
      end
      tests++;
      if (seen != 1) begin fails++; $display("FAIL full_one_req: got %0d requests expected 1", seen); end
      tests++;
      if (q_count !== 5'd16 || inst_pc !== 32'hFFFF_FFF4) begin
         fails++; $display("FAIL full_refill: got %0d/%h expected 16/fffffff4", q_count, inst_pc);
      end
   endtask

   task automatic test_len_err();
      logic [2:0] lens [3];
      lens[0] = 3'd7;
      lens[1] = 3'd0;
      lens[2] = 3'd6;
      test_reset();
      wait_req("lerr_req");
      ack_word(32'h4433_2211);
      for (int k = 0; k < 3; k++) begin
         do_consume(lens[k]);
         tests++;
         if (len_err !== 1'b1) begin fails++; $display("FAIL len_err_pulse%0d: got %0b expected 1", k, len_err); end
         tests++;
         if (q_count !== 5'd4 || inst_pc !== 32'hFFFF_FFF0) begin
            fails++; $display("FAIL len_err_hold%0d: got %0d/%h expected 4/fffffff0", k, q_count, inst_pc);
         end
         step();
         tests++;
         if (len_err !== 1'b0) begin fails++; $display("FAIL len_err_clear%0d: got %0b expected 0", k, len_err); end
      end
      do_consume(3'd4);
      tests++;
      if (len_err !== 1'b0 || q_count !== 5'd0 || inst_pc !== 32'hFFFF_FFF4) begin
         fails++; $display("FAIL len_ok: got %0b/%0d/%h expected 0/0/fffffff4", len_err, q_count, inst_pc);
      end
   endtask

   initial begin
      rst         = 1'b1;
      flush       = 1'b0;
      flush_pc    = 32'h0;
      mem_ack     = 1'b0;
      mem_rdata   = 32'h0;
      consume     = 1'b0;
      consume_len = 3'd0;
      step();
      test_reset();
      test_fill();
      test_consume();
      test_wrap();
      test_flush_align();
      test_flush_pending();
      test_full();
      test_len_err();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
